pipelined_barrel_shifter: RTL
=============================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the team's 16-bit combinational right barrel shifter.
- Supports four shift modes: logical right, logical left, arithmetic right and rotate right.
- One register stage per binary shift weight, with a valid/ready handshake on both sides.
- Sits between an operand source and an ALU result bus; the pipeline sustains one shift per clock when not back-pressured.

Parameters:
- WIDTH, 16, data width in bits; must be a power of two, at least 4.
- SHW, $clog2(WIDTH), shift-amount width and number of pipeline stages; derived, must not be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 LSR, 01 LSL, 10 ASR, 11 ROR.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  result equals 0 (BSH_FLAGS_EN only).
- out_carry  output  1  last bit shifted out (BSH_FLAGS_EN only).

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - SHW stages. Stage k applies a shift of 2^k when shamt bit k is set; otherwise it passes data unchanged.
  - Each stage registers data, remaining shamt, mode, a valid bit and, when flags are enabled, a carry bit.
  - Stage order is LSB weight first (k=0 .. SHW-1). The last stage drives the out_* ports directly from registers; no combinational path from in_* to out_*.
- Stage advance and back-pressure:
  - Stage i loads from stage i-1 when stage i is empty, or when stage i's contents advance this cycle.
  - in_ready = stage 0 empty or stage 0 advancing; it depends on out_ready combinationally through the stage chain.
  - Bubbles collapse: a stalled output does not block upstream stages until those stages are full.
- Latency and throughput:
  - Latency is exactly SHW cycles from input transfer to out_valid, with out_ready held high. WIDTH=16 gives 4 cycles.
  - Throughput is 1 per cycle. Maximum occupancy is SHW transactions, and results leave in acceptance order.
- Mode fill rules (per stage, shift s):
  - LSR: zero fill at the MSB.
  - LSL: zero fill at the LSB.
  - ASR: the original MSB is replicated; the sign is carried through the stages as data[WIDTH-1].
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- Boundary cases:
  - shamt=0 passes in_data unchanged in all modes.
  - shamt=WIDTH-1 is the maximum; no out-of-range values exist.
- Stall:
  - While out_valid && !out_ready, out_data, out_zero and out_carry hold stable.
- Reset:
  - All valid bits clear, out_data=0, out_zero=0, out_carry=0.
  - in_ready is 1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight transactions; none are emitted afterwards.
  - rst has priority over every transfer in the same cycle.
- Simultaneous events:
  - With a full pipeline and out_ready=1, an input transfer and an output transfer occur in the same cycle; occupancy is unchanged.

Optional Feature:
- Macro BSH_FLAGS_EN.
- Defined:
  - out_zero = (out_data == 0), registered alongside out_data.
  - out_carry = last bit shifted out:
    - LSR/ASR: in_data[shamt-1].
    - LSL: in_data[WIDTH-shamt].
    - ROR: out_data[WIDTH-1].
    - shamt=0: carry is 0.
  - Carry is accumulated stage by stage; a stage with an active shift overwrites it.
- Undefined: out_zero and out_carry are tied to 0 and no flag registers are built.

Test Plan:
- Mode checks, one per operation (WIDTH=16):
  - LSR: 0xF00F, shamt 4 -> 0x0F00 after exactly 4 cycles; carry=1 (flags on).
  - LSL: 0x0001, shamt 15 -> 0x8000; carry=0.
  - ASR: 0x8000, shamt 15 -> 0xFFFF. ASR 0x7FF0, shamt 4 -> 0x07FF.
  - ROR: 0x1234, shamt 4 -> 0x4321... no: ROR 0x1234, shamt 4 -> 0x4123; carry=0.
- shamt 0 in all four modes on 0xA5C3 -> 0xA5C3, carry=0, zero=0. LSR 0x000F, shamt 4 -> 0x0000, zero=1, carry=1.
- Back-pressure:
  - Stimulus: stream 8 back-to-back transactions (data 0x0001..0x0008, LSL shamt 1), with out_ready=0 from cycle 2.
  - Required: in_ready drops after 4 are accepted, out_data holds 0x0002 stable, then on release results 0x0002..0x0010 arrive in order with no loss or duplicate.
- Bubble collapse:
  - Stimulus: one transaction in flight and out_ready low for 3 cycles; apply a second input.
  - Required: in_ready stays 1 while empty stages remain.
- Reset mid-flight:
  - Stimulus: 3 transactions in flight, rst high for 1 cycle.
  - Required: out_valid=0 and out_data=0 the next cycle, no stale result ever appears, in_ready=1.

Source files
------------

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for pipelined_barrel_shifter.
// master drives operands and out_ready; slave is the shifter.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_carry;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_carry
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_carry
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// WIDTH-bit LSR/LSL/ASR/ROR shifter with one register stage per shift weight and valid/ready on both sides.
// Define BSH_FLAGS_EN to build the registered zero and carry flags; otherwise they are tied to 0.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic                       clk,
  input logic                       rst,
  pipelined_barrel_shifter_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_LSL = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  logic [SHW-1:0]   r_valid;
  logic [SHW:0]     w_ready;
  logic [SHW-1:0]   w_src_valid;
  logic [WIDTH-1:0] w_q_data  [SHW];
  logic [SHW-1:0]   w_q_shamt [SHW-1];
  logic [1:0]       w_q_mode  [SHW-1];
`ifdef BSH_FLAGS_EN
  logic             w_q_carry [SHW];
  logic             w_zero;
`endif

  // w_ready[i]: stage i may load this cycle (empty, or its contents move on).
  always_comb begin
    w_ready      = '0;
    w_ready[SHW] = bus.out_ready;
    for (int i = SHW - 1; i >= 0; i--) begin
      w_ready[i] = !r_valid[i] || w_ready[i+1];
    end
  end

  assign w_src_valid  = {r_valid[SHW-2:0], bus.in_valid};
  assign bus.in_ready = w_ready[0];

  // NOTE: sequential state uses <= only, so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < SHW; i++) begin
        if (w_ready[i]) r_valid[i] <= w_src_valid[i];
      end
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int S = 1 << k;

    logic [WIDTH-1:0] w_src_data;
    logic [1:0]       w_src_mode;
    logic             w_en;
    logic             w_load;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_nxt_data;
    logic [WIDTH-1:0] r_data;

    if (k == 0) begin : g_head
      assign w_src_data = bus.in_data;
      assign w_src_mode = bus.in_mode;
      assign w_en       = bus.in_shamt[0];
    end else begin : g_body
      assign w_src_data = w_q_data[k-1];
      assign w_src_mode = w_q_mode[k-1];
      assign w_en       = w_q_shamt[k-1][k];
    end

    assign w_load = w_ready[k] && w_src_valid[k];

    // NOTE: w_shifted gets a default before the case, so no latch is inferred for unlisted modes.
    always_comb begin
      w_shifted = w_src_data >> S;
      case (mode_e'(w_src_mode))
        MODE_LSL: w_shifted = w_src_data << S;
        MODE_ASR: w_shifted = (w_src_data >> S) | ({WIDTH{w_src_data[WIDTH-1]}} << (WIDTH - S));
        MODE_ROR: w_shifted = (w_src_data >> S) | (w_src_data << (WIDTH - S));
        default:  w_shifted = w_src_data >> S;
      endcase
    end

    assign w_nxt_data = w_en ? w_shifted : w_src_data;

    // NOTE: payload registers are reset as well so out_data reads 0 after reset, never stale data.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data <= '0;
      end else if (w_load) begin
        r_data <= w_nxt_data;
      end
    end
    assign w_q_data[k] = r_data;

    if (k < SHW - 1) begin : g_ctl
      logic [SHW-1:0] w_src_shamt;
      logic [SHW-1:0] r_shamt;
      logic [1:0]     r_mode;

      if (k == 0) begin : g_in
        assign w_src_shamt = bus.in_shamt;
      end else begin : g_up
        assign w_src_shamt = w_q_shamt[k-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_shamt <= '0;
          r_mode  <= '0;
        end else if (w_load) begin
          r_shamt <= w_src_shamt;
          r_mode  <= w_src_mode;
        end
      end
      assign w_q_shamt[k] = r_shamt;
      assign w_q_mode[k]  = r_mode;
    end

`ifdef BSH_FLAGS_EN
    logic w_src_carry;
    logic w_out_bit;
    logic r_carry;

    if (k == 0) begin : g_c_head
      assign w_src_carry = 1'b0;
    end else begin : g_c_body
      assign w_src_carry = w_q_carry[k-1];
    end

    // The last bit leaving a right shift or rotate is bit S-1; a left shift loses bit WIDTH-S.
    assign w_out_bit = (mode_e'(w_src_mode) == MODE_LSL) ? w_src_data[WIDTH-S] : w_src_data[S-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_carry <= 1'b0;
      end else if (w_load) begin
        r_carry <= w_en ? w_out_bit : w_src_carry;
      end
    end
    assign w_q_carry[k] = r_carry;

    if (k == SHW - 1) begin : g_zero
      logic r_zero;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_zero <= 1'b0;
        end else if (w_load) begin
          r_zero <= (w_nxt_data == '0);
        end
      end
      assign w_zero = r_zero;
    end
`endif
  end

  assign bus.out_valid = r_valid[SHW-1];
  assign bus.out_data  = w_q_data[SHW-1];
`ifdef BSH_FLAGS_EN
  assign bus.out_zero  = w_zero;
  assign bus.out_carry = w_q_carry[SHW-1];
`else
  assign bus.out_zero  = 1'b0;
  assign bus.out_carry = 1'b0;
`endif
endmodule
